// File: rtl/tile_ring_inject_arb.sv
// Injection scheduler for one tile ring: three miss lanes plus writeback share one slot, credit-gated per direction.
// Latency: grant cycle N -> out_en in N+1. Backpressure: rdy only when the source wins and its direction has credit.
module tile_ring_inject_arb #(
    parameter int TILE_X    = 0,
    parameter int TILE_Y    = 0,
    parameter int IDX       = 0,
    parameter int CREDITS   = 8,
    parameter int WB_STARVE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       miss_vld,
    input  logic [2:0][38:0] miss_addr,
    input  logic [2:0][37:0] miss_phy,
    output logic [2:0]       miss_rdy,
    input  logic             wb_vld,
    input  logic [36:0]      wb_addr,
    input  logic [527:0]     wb_data,
    input  logic [37:0]      wb_size,
    output logic             wb_rdy,
    output logic             out_en,
    output logic             out_wb,
    output logic [38:0]      out_addr,
    output logic [527:0]     out_datum,
    output logic [37:0]      out_size,
    output logic             out_fwd,
    input  logic             cred_ret_fwd,
    input  logic             cred_ret_back,
    input  logic             drain_req,
    output logic             drain_ack,
    output logic             credit_err
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    localparam logic [3:0] CRED_MAX   = 4'(CREDITS);
    localparam logic [3:0] STARVE_MAX = 4'(WB_STARVE);
    localparam logic [1:0] TILE_C     = (IDX < 2) ? 2'(TILE_X) : 2'(TILE_Y);

    logic [1:0] state;
    logic [3:0] cred_fwd;
    logic [3:0] cred_back;
    logic [3:0] starve_cnt;
    logic [1:0] rr;

    logic [2:0] lane_fwd;
    logic [2:0] lane_elig;
    logic       fwd_ok;
    logic       back_ok;
    logic       wb_fwd;
    logic       wb_elig;
    logic       wb_force;
    logic       wb_grant;
    logic       any_miss;
    logic       miss_take;
    logic [1:0] miss_sel;
    logic [1:0] cand;
    logic       found;
    logic       grant_any;
    logic       grant_fwd;
    logic       dec_fwd;
    logic       dec_back;

    // Local destinations (coord == tile) travel on the back direction.
    function automatic logic is_fwd(input logic [3:0] a);
        logic [1:0] c;
        c = (IDX < 2) ? a[1:0] : a[3:2];
        return c > TILE_C;
    endfunction

    function automatic logic [1:0] next_lane(input logic [1:0] l);
        return (l == 2'd2) ? 2'd0 : l + 2'd1;
    endfunction

    function automatic logic [3:0] cred_next(input logic [3:0] cur, input logic dec, input logic inc);
        logic [3:0] n;
        n = cur;
        if (dec && !inc)
            n = cur - 4'd1;
        else if (inc && !dec && cur != CRED_MAX)
            n = cur + 4'd1;
        return n;
    endfunction

    assign fwd_ok  = (cred_fwd != 4'd0);
    assign back_ok = (cred_back != 4'd0);

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            lane_fwd[i]  = is_fwd(miss_addr[i][3:0]);
            lane_elig[i] = (state == ST_RUN) && miss_vld[i] && (lane_fwd[i] ? fwd_ok : back_ok);
        end
    end

    always_comb begin
        miss_sel = rr;
        found    = 1'b0;
        cand     = rr;
        for (int k = 0; k < 3; k++) begin
            if (!found && lane_elig[cand]) begin
                miss_sel = cand;
                found    = 1'b1;
            end
            cand = next_lane(cand);
        end
    end

    assign any_miss  = |lane_elig;
    assign wb_fwd    = is_fwd(wb_addr[3:0]);
    assign wb_elig   = (state != ST_HALT) && wb_vld && (wb_fwd ? fwd_ok : back_ok);
    assign wb_force  = wb_elig && (starve_cnt == STARVE_MAX);
    assign wb_grant  = wb_elig && (wb_force || !any_miss);
    assign miss_take = any_miss && !wb_grant;
    assign grant_any = wb_grant || miss_take;
    assign grant_fwd = wb_grant ? wb_fwd : lane_fwd[miss_sel];
    assign dec_fwd   = grant_any && grant_fwd;
    assign dec_back  = grant_any && !grant_fwd;

    always_comb begin
        miss_rdy = 3'b000;
        if (!rst && miss_take)
            miss_rdy[miss_sel] = 1'b1;
    end

    assign wb_rdy    = !rst && wb_grant;
    assign drain_ack = (state == ST_HALT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_en    <= 1'b0;
            out_wb    <= 1'b0;
            out_fwd   <= 1'b0;
            out_addr  <= '0;
            out_datum <= '0;
            out_size  <= '0;
        end else begin
            out_en <= grant_any;
            if (grant_any) begin
                out_wb  <= wb_grant;
                out_fwd <= grant_fwd;
                if (wb_grant) begin
                    out_addr  <= {2'b00, wb_addr};
                    out_datum <= wb_data;
                    out_size  <= wb_size;
                end else begin
                    out_addr  <= miss_addr[miss_sel];
                    out_datum <= '0;
                    out_size  <= miss_phy[miss_sel];
                end
            end
        end
    end

    // A return landing on a full counter means the ring over-returned; it is dropped and flagged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cred_fwd   <= CRED_MAX;
            cred_back  <= CRED_MAX;
            credit_err <= 1'b0;
        end else begin
            cred_fwd  <= cred_next(cred_fwd, dec_fwd, cred_ret_fwd);
            cred_back <= cred_next(cred_back, dec_back, cred_ret_back);
            if ((cred_ret_fwd && !dec_fwd && cred_fwd == CRED_MAX) ||
                (cred_ret_back && !dec_back && cred_back == CRED_MAX))
                credit_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= 4'd0;
            rr         <= 2'd0;
        end else begin
            if (!wb_vld || wb_grant)
                starve_cnt <= 4'd0;
            else if (wb_elig && starve_cnt != STARVE_MAX)
                starve_cnt <= starve_cnt + 4'd1;
            if (miss_take)
                rr <= next_lane(miss_sel);
        end
    end

    // HALT only once nothing is in flight: no wb pending, no beat leaving, all credits home.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            case (state)
                ST_RUN: begin
                    if (drain_req)
                        state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!drain_req)
                        state <= ST_RUN;
                    else if (!wb_vld && cred_fwd == CRED_MAX && cred_back == CRED_MAX && !out_en)
                        state <= ST_HALT;
                end
                ST_HALT: begin
                    if (!drain_req)
                        state <= ST_RUN;
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_ring_inject_arb.sv
// Bench for tile_ring_inject_arb: directed scenarios with literal pins, then randomized traffic vs a behavioural model.
module tb_tile_ring_inject_arb;

    localparam int TX = 1;
    localparam int TY = 2;
    localparam int IX = 0;
    localparam int CR = 8;
    localparam int WS = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [2:0]       miss_vld = '0;
    logic [2:0][38:0] miss_addr = '0;
    logic [2:0][37:0] miss_phy = '0;
    logic [2:0]       miss_rdy;
    logic             wb_vld = 1'b0;
    logic [36:0]      wb_addr = '0;
    logic [527:0]     wb_data = '0;
    logic [37:0]      wb_size = '0;
    logic             wb_rdy;
    logic             out_en, out_wb, out_fwd;
    logic [38:0]      out_addr;
    logic [527:0]     out_datum;
    logic [37:0]      out_size;
    logic             cred_ret_fwd = 1'b0;
    logic             cred_ret_back = 1'b0;
    logic             drain_req = 1'b0;
    logic             drain_ack, credit_err;

    always #5 clk = ~clk;

    tile_ring_inject_arb #(.TILE_X(TX), .TILE_Y(TY), .IDX(IX), .CREDITS(CR), .WB_STARVE(WS)) dut (
        .clk(clk), .rst(rst),
        .miss_vld(miss_vld), .miss_addr(miss_addr), .miss_phy(miss_phy), .miss_rdy(miss_rdy),
        .wb_vld(wb_vld), .wb_addr(wb_addr), .wb_data(wb_data), .wb_size(wb_size), .wb_rdy(wb_rdy),
        .out_en(out_en), .out_wb(out_wb), .out_addr(out_addr), .out_datum(out_datum),
        .out_size(out_size), .out_fwd(out_fwd),
        .cred_ret_fwd(cred_ret_fwd), .cred_ret_back(cred_ret_back),
        .drain_req(drain_req), .drain_ack(drain_ack), .credit_err(credit_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [527:0] act, input logic [527:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic bit dir_fwd(input logic [38:0] a);
        int c, t;
        c = (IX < 2) ? int'(a[1:0]) : int'(a[3:2]);
        t = (IX < 2) ? (TX % 4) : (TY % 4);
        return c > t;
    endfunction

    function automatic int enc(input int q[$]);
        int v = 0;
        foreach (q[i]) v = v * 4 + q[i];
        return v;
    endfunction

    // Model: credits, starvation count, RR start lane, mode (0 run, 1 drain, 2 halt), expected beat.
    int           m_cf, m_cb, m_st, m_rr, m_mode;
    bit           m_err;
    bit           e_en, e_wb, e_fwd;
    logic [38:0]  e_addr;
    logic [527:0] e_dat;
    logic [37:0]  e_size;

    int         glog[$];
    int         flog[$];
    logic [2:0] seen_mr = '0;
    logic       seen_wr = 1'b0;

    always @(negedge clk) begin : cmp_p
        int g, nm, l;
        bit el[3];
        bit anym, wel, wfwd, gf;
        if (rst) begin
            m_cf = CR; m_cb = CR; m_st = 0; m_rr = 0; m_mode = 0; m_err = 0;
            e_en = 0; e_wb = 0; e_fwd = 0; e_addr = '0; e_dat = '0; e_size = '0;
            chk("rst_out_en", out_en, 0);
            chk("rst_out_payload", {out_wb, out_fwd, out_addr, out_size} , 0);
            chk("rst_out_datum", out_datum, 0);
            chk("rst_rdy", {miss_rdy, wb_rdy}, 0);
            chk("rst_flags", {drain_ack, credit_err}, 0);
            seen_mr = '0;
            seen_wr = 1'b0;
        end else begin
            chk("out_en", out_en, e_en);
            chk("out_wb", out_wb, e_wb);
            chk("out_fwd", out_fwd, e_fwd);
            chk("out_addr", out_addr, e_addr);
            chk("out_datum", out_datum, e_dat);
            chk("out_size", out_size, e_size);
            if (out_en) flog.push_back(int'(out_fwd));

            for (int i = 0; i < 3; i++)
                el[i] = (m_mode == 0) && miss_vld[i] && (dir_fwd(miss_addr[i]) ? m_cf > 0 : m_cb > 0);
            wfwd = dir_fwd({2'b00, wb_addr});
            wel  = (m_mode != 2) && wb_vld && (wfwd ? m_cf > 0 : m_cb > 0);
            anym = el[0] || el[1] || el[2];
            g = -1;
            if (wel && (m_st == WS || !anym)) g = 3;
            else for (int k = 0; k < 3; k++) begin
                l = (m_rr + k) % 3;
                if (g < 0 && el[l]) g = l;
            end

            chk("miss_rdy", miss_rdy, (g >= 0 && g < 3) ? (3'b001 << g) : 3'b000);
            chk("wb_rdy", wb_rdy, g == 3);
            chk("drain_ack", drain_ack, m_mode == 2);
            chk("credit_err", credit_err, m_err);
            seen_mr = miss_rdy;
            seen_wr = wb_rdy;
            if (miss_rdy != 0 || wb_rdy)
                glog.push_back(wb_rdy ? 3 : (miss_rdy[0] ? 0 : (miss_rdy[1] ? 1 : 2)));

            nm = m_mode;
            if (m_mode == 0) begin
                if (drain_req) nm = 1;
            end else if (m_mode == 1) begin
                if (!drain_req) nm = 0;
                else if (!wb_vld && m_cf == CR && m_cb == CR && !e_en) nm = 2;
            end else if (!drain_req) nm = 0;

            if (!wb_vld || g == 3) m_st = 0;
            else if (wel && m_st < WS) m_st++;

            gf = (g == 3) ? wfwd : ((g >= 0) ? dir_fwd(miss_addr[g]) : 1'b0);
            if (g >= 0 && gf && !cred_ret_fwd) m_cf--;
            else if (cred_ret_fwd && !(g >= 0 && gf)) begin
                if (m_cf == CR) m_err = 1; else m_cf++;
            end
            if (g >= 0 && !gf && !cred_ret_back) m_cb--;
            else if (cred_ret_back && !(g >= 0 && !gf)) begin
                if (m_cb == CR) m_err = 1; else m_cb++;
            end
            if (g >= 0 && g < 3) m_rr = (g + 1) % 3;
            m_mode = nm;

            e_en = (g >= 0);
            if (g == 3) begin
                e_wb = 1; e_fwd = gf; e_addr = {2'b00, wb_addr}; e_dat = wb_data; e_size = wb_size;
            end else if (g >= 0) begin
                e_wb = 0; e_fwd = gf; e_addr = miss_addr[g]; e_dat = '0; e_size = miss_phy[g];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) if (seen_mr[i]) miss_vld[i] = 1'b0;
        if (seen_wr) wb_vld = 1'b0;
        cred_ret_fwd  = 1'b0;
        cred_ret_back = 1'b0;
    endtask

    task automatic set_miss(input int l, input logic [1:0] lo);
        logic [38:0] a;
        a = 39'({$urandom(), $urandom()});
        a[1:0] = lo;
        miss_addr[l] = a;
        miss_phy[l]  = 38'({$urandom(), $urandom()});
        miss_vld[l]  = 1'b1;
    endtask

    task automatic set_wb(input logic [1:0] lo);
        logic [36:0] a;
        a = 37'({$urandom(), $urandom()});
        a[1:0] = lo;
        wb_addr = a;
        for (int j = 0; j < 16; j++) wb_data[j*32 +: 32] = $urandom();
        wb_data[527:512] = 16'($urandom());
        wb_size = 38'({$urandom(), $urandom()});
        wb_vld  = 1'b1;
    endtask

    task automatic ret(input int nf, input int nb);
        for (int i = 0; i < ((nf > nb) ? nf : nb); i++) begin
            cred_ret_fwd  = (i < nf);
            cred_ret_back = (i < nb);
            tick();
        end
    endtask

    task automatic grant_fwd(input int n);
        int n0;
        n0 = glog.size();
        set_miss(0, 2'd2);
        for (int c = 0; c < 4 * n + 4; c++) begin
            tick();
            if (glog.size() >= n0 + n) break;
            if (!miss_vld[0]) set_miss(0, 2'd2);
        end
        miss_vld[0] = 1'b0;
    endtask

    initial begin
        int n0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Three lanes, addr[1:0]=2,0,3 against TILE_X=1: fwd, back, fwd.
        glog.delete(); flog.delete();
        set_miss(0, 2'd2); set_miss(1, 2'd0); set_miss(2, 2'd3);
        repeat (5) tick();
        chk("s1_grant_order", enc(glog), 6);
        chk("s1_grant_count", glog.size(), 3);
        chk("s1_out_fwd_seq", enc(flog), 17);
        chk("s1_model_cred", {4'(m_cf), 4'(m_cb)}, {4'd6, 4'd7});
        chk("s1_dut_cred", {dut.cred_fwd, dut.cred_back}, {4'd6, 4'd7});
        ret(2, 1);

        // Writeback starvation: lanes 0/1 always valid, wb wins on the 5th arbitration.
        glog.delete();
        set_wb(2'd0); set_miss(0, 2'd2); set_miss(1, 2'd3);
        for (int c = 0; c < 10; c++) begin
            tick();
            if (glog.size() >= 5) break;
            if (!miss_vld[0]) set_miss(0, 2'd2);
            if (!miss_vld[1]) set_miss(1, 2'd3);
        end
        miss_vld = '0;
        chk("s2_grant_order", enc(glog), 71);
        chk("s2_out_wb", {out_en, out_wb}, 2'b11);
        chk("s2_starve_clear", dut.starve_cnt, 0);
        ret(4, 1);
        chk("s2_model_cred", {4'(m_cf), 4'(m_cb)}, {4'd8, 4'd8});

        // Exhaust fwd credits; back traffic continues; one return frees a fwd grant.
        glog.delete();
        grant_fwd(8);
        chk("s3_fwd_grants", glog.size(), 8);
        chk("s3_dut_cred_fwd0", dut.cred_fwd, 0);
        chk("s3_model_cred_fwd0", 4'(m_cf), 0);
        n0 = glog.size();
        set_miss(0, 2'd3); set_miss(1, 2'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            if (!miss_vld[1]) set_miss(1, 2'd0);
        end
        miss_vld[1] = 1'b0;
        chk("s3_back_only", enc(glog[n0:$]), 21);
        n0 = glog.size();
        cred_ret_fwd = 1'b1;
        tick();
        tick();
        chk("s3_fwd_after_ret", enc(glog[n0:$]), 0);
        chk("s3_fwd_after_ret_n", glog.size() - n0, 1);
        ret(8, 3);

        // Over-return sets sticky error; simultaneous grant+return holds the count.
        cred_ret_fwd = 1'b1;
        tick();
        tick();
        chk("s4_err_set", credit_err, 1);
        repeat (3) tick();
        chk("s4_err_sticky", credit_err, 1);
        chk("s4_cred_full", dut.cred_fwd, 8);
        grant_fwd(5);
        chk("s4_cred3", dut.cred_fwd, 3);
        set_miss(0, 2'd2);
        cred_ret_fwd = 1'b1;
        tick();
        chk("s4_grant_ret_hold", dut.cred_fwd, 3);
        chk("s4_model_hold", 4'(m_cf), 3);
        ret(5, 0);

        // Drain: only wb is granted after RUN exits; HALT once credits are home.
        glog.delete();
        set_miss(0, 2'd2); set_miss(1, 2'd0); set_wb(2'd3);
        drain_req = 1'b1;
        for (int c = 0; c < 40; c++) begin
            cred_ret_fwd  = (m_cf < CR);
            cred_ret_back = (m_cb < CR);
            tick();
            if (drain_ack) break;
        end
        chk("s5_drain_ack", drain_ack, 1);
        chk("s5_grants", enc(glog), 7);
        chk("s5_lane0_waiting", miss_vld[0], 1);
        drain_req = 1'b0;
        tick();
        chk("s5_ack_drop", drain_ack, 0);
        tick();
        chk("s5_miss_resume", glog[$], 0);
        ret(1, 0);

        // Reset the cycle after a grant: the pending beat disappears.
        set_miss(2, 2'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        miss_vld = '0;
        #1;
        chk("s6_out_en_in_rst", out_en, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        chk("s6_no_stale", out_en, 0);
        chk("s6_cred_restored", {dut.cred_fwd, dut.cred_back}, {4'd8, 4'd8});

        // Randomized traffic, returns, drains and resets.
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (rst) begin
                rst = 1'b0;
            end else if ($urandom_range(0, 399) == 0) begin
                rst = 1'b1;
            end
            for (int i = 0; i < 3; i++)
                if (!miss_vld[i] && $urandom_range(0, 2) == 0) set_miss(i, 2'($urandom_range(0, 3)));
            if (!wb_vld && $urandom_range(0, 4) == 0) set_wb(2'($urandom_range(0, 3)));
            cred_ret_fwd  = (m_cf < CR) && ($urandom_range(0, 2) == 0);
            cred_ret_back = (m_cb < CR) && ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 199) == 0) cred_ret_fwd = 1'b1;
            if ($urandom_range(0, 99) == 0) drain_req = ~drain_req;
        end
        rst = 1'b0;
        drain_req = 1'b0;
        miss_vld = '0;
        wb_vld = 1'b0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout reached");
        $fatal(1);
    end

endmodule
